// File: rtl/alarm_pkg.sv
// Shared definitions for the car-alarm datapath: timer state encodings and
// interval selector codes consumed by time_parameters.
package alarm_pkg;

    typedef enum logic [1:0] {
        TMR_IDLE  = 2'b00,
        TMR_COUNT = 2'b01,
        TMR_DONE  = 2'b10,
        TMR_BAD   = 2'b11
    } tmr_state_t;

    typedef enum logic [1:0] {
        T_ARM_DELAY       = 2'b00,
        T_DRIVER_DELAY    = 2'b01,
        T_PASSENGER_DELAY = 2'b10,
        T_ALARM_ON        = 2'b11
    } interval_sel_t;

endpackage

// File: rtl/countdown_timer_prescaler.sv
// Free-running one-second prescaler with synchronous clear; derives the
// 1 Hz / 0.5 Hz enables and the 2 s blink level.
module one_hz_prescaler #(
    parameter int CYCLES_PER_SEC = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick,
    output logic one_hz_enable,
    output logic half_hz_enable,
    output logic blink
);

    localparam int CNT_W = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CYCLES_PER_SEC - 1);

    logic [CNT_W-1:0] count;
    logic             phase;

    assign tick = (count == TERM);

    // A clear restarts the whole second, so the enables and blink realign too.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count          <= '0;
            phase          <= 1'b0;
            one_hz_enable  <= 1'b0;
            half_hz_enable <= 1'b0;
            blink          <= 1'b0;
        end else if (clear) begin
            count          <= '0;
            phase          <= 1'b0;
            one_hz_enable  <= 1'b0;
            half_hz_enable <= 1'b0;
            blink          <= 1'b0;
        end else begin
            count          <= tick ? '0 : count + 1'b1;
            one_hz_enable  <= tick;
            half_hz_enable <= tick & phase;
            if (tick) begin
                phase <= ~phase;
                blink <= ~blink;
            end
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Seconds countdown for the alarm/disarm FSMs; expired holds while the
// requester keeps start_timer high.
//
// state     | meaning
// TMR_IDLE  | no countdown owned, remaining = 0
// TMR_COUNT | counting down, busy = 1
// TMR_DONE  | interval elapsed, expired = 1 until start_timer drops
module countdown_timer
    import alarm_pkg::*;
#(
    parameter int CYCLES_PER_SEC = 50_000_000,
    parameter int VALUE_W        = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [VALUE_W-1:0] value,
    input  logic               start_timer,
    output logic               expired,
    output logic               busy,
    output logic [VALUE_W-1:0] remaining,
    output logic               one_hz_enable,
    output logic               half_hz_enable,
    output logic               blink
);

    tmr_state_t         state, state_nxt;
    logic [VALUE_W-1:0] rem_nxt;
    logic               start_d;
    logic               start_edge;
    logic               tick;

    assign start_edge = start_timer & ~start_d;

    one_hz_prescaler #(
        .CYCLES_PER_SEC(CYCLES_PER_SEC)
    ) u_prescaler (
        .clock         (clock),
        .reset         (reset),
        .clear         (start_edge),
        .tick          (tick),
        .one_hz_enable (one_hz_enable),
        .half_hz_enable(half_hz_enable),
        .blink         (blink)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= TMR_IDLE;
            remaining <= '0;
            start_d   <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= rem_nxt;
            start_d   <= start_timer;
        end
    end

    always_comb begin
        state_nxt = state;
        rem_nxt   = remaining;
        case (state)
            TMR_IDLE, TMR_DONE: begin
                if (start_edge) begin
                    if (value != '0) begin
                        state_nxt = TMR_COUNT;
                        rem_nxt   = value;
                    end else begin
                        state_nxt = TMR_DONE;
                        rem_nxt   = '0;
                    end
                end else if (!start_timer) begin
                    state_nxt = TMR_IDLE;
                    rem_nxt   = '0;
                end
            end
            TMR_COUNT: begin
                // Abort, then restart, then tick.
                if (!start_timer) begin
                    state_nxt = TMR_IDLE;
                    rem_nxt   = '0;
                end else if (start_edge) begin
                    if (value != '0) begin
                        rem_nxt = value;
                    end else begin
                        state_nxt = TMR_DONE;
                        rem_nxt   = '0;
                    end
                end else if (tick) begin
                    if (remaining <= VALUE_W'(1)) begin
                        state_nxt = TMR_DONE;
                        rem_nxt   = '0;
                    end else begin
                        rem_nxt = remaining - 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = TMR_IDLE;
                rem_nxt   = '0;
            end
        endcase
    end

    assign busy    = (state == TMR_COUNT);
    assign expired = (state == TMR_DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Randomised and directed check of countdown_timer against a deadline-based
// model of seconds elapsed since the last start or reset.
module tb_countdown_timer;

    localparam int CPS = 4;
    localparam int VW  = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [VW-1:0] value = '0;
    logic          start_timer = 1'b1;
    logic          expired, busy, one_hz_enable, half_hz_enable, blink;
    logic [VW-1:0] remaining;

    int n_checks = 0;
    int n_fail   = 0;

    countdown_timer #(.CYCLES_PER_SEC(CPS), .VALUE_W(VW)) dut (
        .clock         (clock),
        .reset         (reset),
        .value         (value),
        .start_timer   (start_timer),
        .expired       (expired),
        .busy          (busy),
        .remaining     (remaining),
        .one_hz_enable (one_hz_enable),
        .half_hz_enable(half_hz_enable),
        .blink         (blink)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: edge index n since reset, last sync edge s, countdown deadline.
    int m_n, m_s, m_dl;
    bit m_cnt, m_done, m_prev;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_n = 0; m_s = 0; m_dl = 0;
            m_cnt = 0; m_done = 0; m_prev = 0;
        end else begin
            bit st_edge;
            m_n++;
            st_edge = start_timer && !m_prev;
            m_prev  = start_timer;
            if (st_edge) begin
                m_s = m_n;
                if (value == 0) begin
                    m_cnt = 0; m_done = 1;
                end else begin
                    m_cnt = 1; m_done = 0;
                    m_dl  = m_n + int'(value) * CPS;
                end
            end else if (!start_timer) begin
                m_cnt = 0; m_done = 0;
            end else if (m_cnt && m_n == m_dl) begin
                m_cnt = 0; m_done = 1;
            end
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            chk("rst_expired", int'(expired), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_remaining", int'(remaining), 0);
            chk("rst_one_hz", int'(one_hz_enable), 0);
            chk("rst_half_hz", int'(half_hz_enable), 0);
            chk("rst_blink", int'(blink), 0);
        end else begin
            int d, p, e_one, e_rem;
            d     = m_n - m_s;
            p     = d / CPS;
            e_one = (d > 0 && d % CPS == 0) ? 1 : 0;
            e_rem = m_cnt ? (m_dl - m_n + CPS - 1) / CPS : 0;
            chk("m_expired", int'(expired), int'(m_done));
            chk("m_busy", int'(busy), int'(m_cnt));
            chk("m_remaining", int'(remaining), e_rem);
            chk("m_one_hz", int'(one_hz_enable), e_one);
            chk("m_half_hz", int'(half_hz_enable), (e_one == 1 && p % 2 == 0) ? 1 : 0);
            chk("m_blink", int'(blink), p % 2);
        end
    end

    task automatic tick();
        @(negedge clock);
        #2;
    endtask

    initial begin
        int one_cnt, half_cnt, blink_tg;
        logic blink_prev;

        // 1: reset with start held high, then free-running enables
        repeat (3) tick();
        chk("t1_rst_expired", int'(expired), 0);
        start_timer = 1'b0;
        reset = 1'b1;
        one_cnt = 0; half_cnt = 0; blink_tg = 0; blink_prev = blink;
        repeat (16) begin
            tick();
            one_cnt  += int'(one_hz_enable);
            half_cnt += int'(half_hz_enable);
            if (blink != blink_prev) blink_tg++;
            blink_prev = blink;
        end
        chk("t1_one_hz_count", one_cnt, 4);
        chk("t1_half_hz_count", half_cnt, 2);
        chk("t1_blink_toggles", blink_tg, 4);
        chk("t1_idle_busy", int'(busy), 0);

        // 2: V=3 expires exactly 12 edges after load
        value = 4'd3; start_timer = 1'b1;
        tick();
        chk("t2_busy", int'(busy), 1);
        chk("t2_rem3", int'(remaining), 3);
        repeat (4) tick();
        chk("t2_rem2", int'(remaining), 2);
        repeat (4) tick();
        chk("t2_rem1", int'(remaining), 1);
        repeat (3) tick();
        chk("t2_not_yet", int'(expired), 0);
        tick();
        chk("t2_expired", int'(expired), 1);
        chk("t2_rem0", int'(remaining), 0);
        repeat (3) tick();
        chk("t2_expired_hold", int'(expired), 1);
        start_timer = 1'b0;
        tick();
        chk("t2_cleared", int'(expired), 0);

        // 3: V=0 goes straight to DONE
        value = 4'd0; start_timer = 1'b1;
        tick();
        chk("t3_expired", int'(expired), 1);
        chk("t3_busy", int'(busy), 0);
        start_timer = 1'b0;
        tick();

        // 4: abort mid-count
        value = 4'd5; start_timer = 1'b1;
        repeat (6) tick();
        chk("t4_rem", int'(remaining), 4);
        start_timer = 1'b0;
        tick();
        chk("t4_busy", int'(busy), 0);
        chk("t4_rem0", int'(remaining), 0);
        chk("t4_expired", int'(expired), 0);

        // 5: drop one cycle at remaining=2, restart with V=2
        value = 4'd4; start_timer = 1'b1;
        repeat (9) tick();
        chk("t5_rem2", int'(remaining), 2);
        start_timer = 1'b0;
        tick();
        chk("t5_idle", int'(busy), 0);
        value = 4'd2; start_timer = 1'b1;
        tick();
        chk("t5_reload", int'(remaining), 2);
        repeat (7) tick();
        chk("t5_not_yet", int'(expired), 0);
        tick();
        chk("t5_expired", int'(expired), 1);
        start_timer = 1'b0;
        tick();

        // 6: asynchronous reset mid-count
        value = 4'd2; start_timer = 1'b1;
        repeat (3) tick();
        @(posedge clock);
        #1 reset = 1'b0;
        #1;
        chk("t6_async_busy", int'(busy), 0);
        chk("t6_async_rem", int'(remaining), 0);
        chk("t6_async_blink", int'(blink), 0);
        start_timer = 1'b0;
        tick();
        reset = 1'b1;
        repeat (20) tick();
        chk("t6_no_expire", int'(expired), 0);

        // Random traffic, checked cycle by cycle against the model
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                reset = 1'b0;
                tick();
                reset = 1'b1;
            end
            value       = VW'($urandom_range(0, 15));
            start_timer = ($urandom_range(0, 3) != 0) ? ~start_timer : start_timer;
            repeat ($urandom_range(1, 40)) begin
                tick();
                if ($urandom_range(0, 7) == 0) value = VW'($urandom_range(0, 15));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Countdown timer for the car-alarm datapath.
- Consumes the 4-bit interval `value` from time_parameters and the `start_timer` request from the alarm/disarm FSMs.
- Produces `expired` back to those FSMs.
- Produces the 1 Hz / 0.5 Hz enables and a 2 s-period blink level used to drive the status indicator in the armed state.

Parameters:
CYCLES_PER_SEC, 50_000_000, clock cycles per second; prescaler terminal count is CYCLES_PER_SEC-1. Must be >= 2.
VALUE_W, 4, width of the `value` and `remaining` buses.

Ports:
clock  input  1  system clock; all state changes on its rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
value  input  VALUE_W  countdown length in seconds; sampled only on a start edge
start_timer  input  1  level request; a 0->1 edge loads and starts; holding 1 keeps the timer owned; 0 aborts or clears
expired  output  1  level, high while in DONE
busy  output  1  high while in COUNT
remaining  output  VALUE_W  seconds left; 0 when IDLE or DONE
one_hz_enable  output  1  single-cycle pulse once per second
half_hz_enable  output  1  single-cycle pulse every second one_hz_enable
blink  output  1  toggles on each one_hz_enable (period 2 s)

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; prescaler=0; start_d=0.
  - expired=0, busy=0, remaining=0, one_hz_enable=0, half_hz_enable=0, blink=0, half phase=0.
- Start edge: start_edge = start_timer & ~start_d, where start_d is a registered copy of start_timer.
- Prescaler:
  - Counts 0..CYCLES_PER_SEC-1 and wraps.
  - one_hz_enable is registered: high for the one cycle after the edge where prescaler == CYCLES_PER_SEC-1.
  - A start_edge forces the prescaler to 0, so the first countdown second is a full CYCLES_PER_SEC cycles. A start_edge also resynchronises one_hz_enable, half_hz_enable and blink; this is intended.
- half_hz_enable: a phase bit toggles on each one_hz_enable; half_hz_enable = one_hz_enable & phase (registered with one_hz_enable).
- blink: toggles on each one_hz_enable.
- State encodings: IDLE=2'b00, COUNT=2'b01, DONE=2'b10; 2'b11 recovers to IDLE.
- IDLE:
  - start_edge & value!=0 -> COUNT, remaining<=value.
  - start_edge & value==0 -> DONE.
- COUNT:
  - start_timer==0 -> IDLE, remaining<=0 (abort; expired never asserts).
  - Else start_edge -> reload remaining<=value and clear prescaler (restart), or go to DONE if value==0.
  - Else on an internal tick with remaining==1 -> DONE, remaining<=0.
  - Else on an internal tick -> remaining<=remaining-1.
- DONE:
  - start_timer==0 -> IDLE.
  - start_edge -> same as from IDLE. This is unreachable without a low cycle in between; stated for completeness.
  - expired stays high while start_timer stays high.
- Internal tick: the same cycle condition that raises one_hz_enable on the next edge, i.e. prescaler == CYCLES_PER_SEC-1.
- Latency: start edge sampled at clock edge k with value=V>0 -> expired rises at edge k+V*CYCLES_PER_SEC. With V==0, expired rises at edge k+1.
- Unsigned arithmetic; no underflow, since remaining is never decremented at 0.
- Simultaneous events:
  - Abort has priority over tick.
  - Restart has priority over tick.
  - Reset has priority over everything.
- Changing `value` mid-count has no effect until the next start edge.

Decomposition:
- Shared package alarm_pkg holds:
  - Timer state encodings: TMR_IDLE, TMR_COUNT, TMR_DONE.
  - Interval selector codes used by time_parameters: T_ARM_DELAY, T_DRIVER_DELAY, T_PASSENGER_DELAY, T_ALARM_ON.
- One sub-module is natural: one_hz_prescaler.
  - Holds the prescaler counter, a synchronous clear input, the registered one_hz_enable, the half-Hz phase and blink.
  - The countdown FSM lives in countdown_timer.

Test Plan:
1. CYCLES_PER_SEC=4. Hold reset=0 3 cycles with start_timer=1 -> all outputs 0 during reset. Release reset with start_timer low -> state IDLE, one_hz_enable pulses every 4 cycles, half_hz_enable every 8, blink toggles every 4.
2. value=3, raise start_timer and hold -> busy=1 next edge, remaining 3,2,1. Expired rises exactly 12 cycles after the load edge and stays high; start_timer low -> expired=0 next edge.
3. value=0, start edge -> expired=1 after 1 cycle, busy never asserted.
4. value=5, start, drop start_timer after 6 cycles -> IDLE next edge, remaining=0, expired never asserted.
5. value=4, start; at remaining=2 pulse start low one cycle and high again with value=2 -> IDLE then reload. Expired rises 8 cycles after the restart edge.
6. value=2, assert reset=0 mid-count -> outputs 0 asynchronously (before the next clock edge). After release, no expired without a new start edge.
